// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and framebuffer-fetch engine with latency-aligned sync/DE/RGB
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SCALE    = 1,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic [3*COLOR_W-1:0] mem_data,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   grn,
  output logic [COLOR_W-1:0]   blu,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start,
  output logic                 line_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [1:0]    S_LAST     = 2'(SCALE - 1);

  logic                 run_q, run_d;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic [VW-1:0]        vcnt_q, vcnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d, base_q, base_d, mem_addr_q;
  logic [1:0]           sh_q, sh_d, sv_q, sv_d;
  logic                 mem_rd_q, hs0_q, vs0_q;
  logic [MEM_LAT:0]     de_p_q, hs_p_q, vs_p_q;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 h_end, f_end, de_raw, hs_raw, vs_raw, line_end, last_line, src_next;

  always_comb begin
    h_end     = hcnt_q == H_LAST;
    f_end     = h_end && vcnt_q == V_LAST;
    de_raw    = run_q && hcnt_q < H_ACT && vcnt_q < V_ACT;
    hs_raw    = run_q && hcnt_q >= HS_BEG && hcnt_q <= HS_LAST;
    vs_raw    = run_q && vcnt_q >= VS_BEG && vcnt_q <= VS_LAST;
    line_end  = de_raw && hcnt_q == H_ACT_LAST;
    last_line = vcnt_q == V_ACT_LAST;
    src_next  = last_line || sv_q == S_LAST;
    run_d     = run_q ? (f_end ? en : 1'b1) : en;
    hcnt_d    = (!run_q || h_end) ? '0 : hcnt_q + 1'b1;
    vcnt_d    = (!run_q || f_end) ? '0 : h_end ? vcnt_q + 1'b1 : vcnt_q;
    sh_d      = !de_raw ? sh_q : sh_q == S_LAST ? '0 : sh_q + 1'b1;
    sv_d      = !line_end ? sv_q : src_next ? '0 : sv_q + 1'b1;
    // a line that is not the last replica of its source line rewinds to line_base
    addr_d    = !de_raw ? addr_q :
                line_end ? (last_line ? '0 : sv_q != S_LAST ? base_q : addr_q + 1'b1) :
                sh_q == S_LAST ? addr_q + 1'b1 : addr_q;
    base_d    = (line_end && src_next) ? (last_line ? '0 : addr_q + 1'b1) : base_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      sh_q       <= '0;
      sv_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      hs0_q      <= ~HS_POL;
      vs0_q      <= ~VS_POL;
      de_p_q     <= '0;
      hs_p_q     <= {(MEM_LAT+1){~HS_POL}};
      vs_p_q     <= {(MEM_LAT+1){~VS_POL}};
      rgb_q      <= '0;
    end else begin
      run_q      <= run_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      sh_q       <= sh_d;
      sv_q       <= sv_d;
      mem_addr_q <= addr_q;
      mem_rd_q   <= de_raw;
      hs0_q      <= hs_raw ? HS_POL : ~HS_POL;
      vs0_q      <= vs_raw ? VS_POL : ~VS_POL;
      de_p_q     <= {de_p_q[MEM_LAT-1:0], mem_rd_q};
      hs_p_q     <= {hs_p_q[MEM_LAT-1:0], hs0_q};
      vs_p_q     <= {vs_p_q[MEM_LAT-1:0], vs0_q};
      // de_p_q[MEM_LAT-1] belongs to the pixel whose data is on mem_data now
      rgb_q      <= de_p_q[MEM_LAT-1] ? mem_data : '0;
    end
  end

  assign mem_addr          = mem_addr_q;
  assign mem_rd            = mem_rd_q;
  assign {blu, grn, red}   = rgb_q;
  assign hsync             = hs_p_q[MEM_LAT];
  assign vsync             = vs_p_q[MEM_LAT];
  assign de                = de_p_q[MEM_LAT];
  assign frame_start       = run_q && hcnt_q == '0 && vcnt_q == '0;
  assign line_start        = run_q && hcnt_q == '0 && vcnt_q < V_ACT;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a small 16x8 timing, one unscaled instance and one SCALE=2/MEM_LAT=3/active-high instance
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic [11:0] addr_a, addr_b, mdat_a, m1_b, m2_b, mdat_b;
  logic rd_a, rd_b, hs_a, vs_a, de_a, fs_a, ls_a, hs_b, vs_b, de_b, fs_b, ls_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  int errors = 0;
  int checks = 0;

  // framebuffer models: data equals address, MEM_LAT cycles after the read
  always @(posedge clk) begin
    mdat_a <= addr_a;
    m1_b   <= addr_b;
    m2_b   <= m1_b;
    mdat_b <= m2_b;
  end

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ADDR_W(12)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mem_addr(addr_a), .mem_rd(rd_a), .mem_data(mdat_a),
    .red(r_a), .grn(g_a), .blu(b_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .frame_start(fs_a), .line_start(ls_a));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .SCALE(2), .MEM_LAT(3), .ADDR_W(12)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mem_addr(addr_b), .mem_rd(rd_b), .mem_data(mdat_b),
    .red(r_b), .grn(g_b), .blu(b_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .frame_start(fs_b), .line_start(ls_b));

  // frame position (0..127) of dut_a at bench cycle j, -1 while idle; en drops at 276 and returns at 423
  function automatic int pos_a(int j);
    if (j < 0 || (j >= 384 && j < 424)) return -1;
    return j < 384 ? j % 128 : (j - 424) % 128;
  endfunction
  function automatic int pos_b(int j);
    return j < 0 ? -1 : j % 128;
  endfunction
  function automatic bit act(int p);
    return p >= 0 && p % 16 < 8 && p / 16 < 4;
  endfunction
  function automatic bit hsa(int p);
    return p >= 0 && p % 16 >= 10 && p % 16 <= 12;
  endfunction
  function automatic bit vsa(int p);
    return p >= 0 && p / 16 >= 5 && p / 16 <= 6;
  endfunction
  function automatic logic [11:0] adr1(int p);
    return 12'((p / 16) * 8 + p % 16);
  endfunction
  function automatic logic [11:0] adr2(int p);
    return 12'((p / 32) * 4 + (p % 16) / 2);
  endfunction

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (de_a !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", de_a); end
    checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL reset_hsync_a got=%b exp=1", hs_a); end
    checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL reset_vsync_a got=%b exp=1", vs_a); end
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", rd_a); end
    checks++; if (addr_a !== 12'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
    checks++; if ({b_a, g_a, r_a} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", {b_a, g_a, r_a}); end
    checks++; if (fs_a !== 1'b0 || ls_a !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", fs_a, ls_a); end
    checks++; if (hs_b !== 1'b0) begin errors++; $display("FAIL reset_hsync_b got=%b exp=0", hs_b); end
    checks++; if (vs_b !== 1'b0) begin errors++; $display("FAIL reset_vsync_b got=%b exp=0", vs_b); end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (fs_a !== 1'b0 || de_a !== 1'b0 || rd_a !== 1'b0)
        begin errors++; $display("FAIL idle i=%0d got fs/de/rd=%b%b%b exp=000", i, fs_a, de_a, rd_a); end
    end
  endtask

  task automatic test_sync_de;
    int p0, p3;
    en_a = 1'b1;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      p0 = pos_a(k); p3 = pos_a(k - 3);
      checks++; if (fs_a !== (p0 == 0)) begin errors++; $display("FAIL sync_fs k=%0d got=%b exp=%b", k, fs_a, p0 == 0); end
      checks++; if (ls_a !== (p0 >= 0 && p0 % 16 == 0 && p0 / 16 < 4))
        begin errors++; $display("FAIL sync_ls k=%0d got=%b", k, ls_a); end
      checks++; if (de_a !== act(p3)) begin errors++; $display("FAIL sync_de k=%0d got=%b exp=%b", k, de_a, act(p3)); end
      checks++; if (hs_a !== !hsa(p3)) begin errors++; $display("FAIL sync_hs k=%0d got=%b exp=%b", k, hs_a, !hsa(p3)); end
      checks++; if (vs_a !== !vsa(p3)) begin errors++; $display("FAIL sync_vs k=%0d got=%b exp=%b", k, vs_a, !vsa(p3)); end
    end
  endtask

  task automatic test_fetch_data;
    int p1, p3;
    for (int k = 128; k < 256; k++) begin
      @(negedge clk);
      p1 = pos_a(k - 1); p3 = pos_a(k - 3);
      checks++; if (rd_a !== act(p1)) begin errors++; $display("FAIL fetch_rd k=%0d got=%b exp=%b", k, rd_a, act(p1)); end
      if (act(p1)) begin
        checks++; if (addr_a !== adr1(p1)) begin errors++; $display("FAIL fetch_addr k=%0d got=%0d exp=%0d", k, addr_a, adr1(p1)); end
      end
      checks++; if (de_a !== act(p3)) begin errors++; $display("FAIL fetch_de k=%0d got=%b exp=%b", k, de_a, act(p3)); end
      checks++; if ({b_a, g_a, r_a} !== (act(p3) ? adr1(p3) : 12'h000))
        begin errors++; $display("FAIL fetch_rgb k=%0d got=%h exp=%h", k, {b_a, g_a, r_a}, act(p3) ? adr1(p3) : 12'h000); end
    end
  endtask

  task automatic test_en_drop;
    int p0, p1, p3;
    for (int k = 256; k < 461; k++) begin
      @(negedge clk);
      p0 = pos_a(k); p1 = pos_a(k - 1); p3 = pos_a(k - 3);
      checks++; if (fs_a !== (p0 == 0)) begin errors++; $display("FAIL endrop_fs k=%0d got=%b exp=%b", k, fs_a, p0 == 0); end
      checks++; if (rd_a !== act(p1)) begin errors++; $display("FAIL endrop_rd k=%0d got=%b exp=%b", k, rd_a, act(p1)); end
      checks++; if (de_a !== act(p3)) begin errors++; $display("FAIL endrop_de k=%0d got=%b exp=%b", k, de_a, act(p3)); end
      checks++; if (hs_a !== !hsa(p3) || vs_a !== !vsa(p3))
        begin errors++; $display("FAIL endrop_sync k=%0d got=%b%b exp=%b%b", k, hs_a, vs_a, !hsa(p3), !vsa(p3)); end
      checks++; if ({b_a, g_a, r_a} !== (act(p3) ? adr1(p3) : 12'h000))
        begin errors++; $display("FAIL endrop_rgb k=%0d got=%h", k, {b_a, g_a, r_a}); end
      if (k == 276) en_a = 1'b0;
      if (k == 423) en_a = 1'b1;
    end
  endtask

  task automatic test_scale_latency;
    int p0, p1, p5;
    en_b = 1'b1;
    for (int k = 0; k < 141; k++) begin
      @(negedge clk);
      p0 = pos_b(k); p1 = pos_b(k - 1); p5 = pos_b(k - 5);
      checks++; if (fs_b !== (p0 == 0)) begin errors++; $display("FAIL scale_fs k=%0d got=%b exp=%b", k, fs_b, p0 == 0); end
      checks++; if (rd_b !== act(p1)) begin errors++; $display("FAIL scale_rd k=%0d got=%b exp=%b", k, rd_b, act(p1)); end
      if (act(p1)) begin
        checks++; if (addr_b !== adr2(p1)) begin errors++; $display("FAIL scale_addr k=%0d got=%0d exp=%0d", k, addr_b, adr2(p1)); end
      end
      checks++; if (de_b !== act(p5)) begin errors++; $display("FAIL scale_de k=%0d got=%b exp=%b", k, de_b, act(p5)); end
      checks++; if (hs_b !== hsa(p5) || vs_b !== vsa(p5))
        begin errors++; $display("FAIL scale_sync k=%0d got=%b%b exp=%b%b", k, hs_b, vs_b, hsa(p5), vsa(p5)); end
      checks++; if ({b_b, g_b, r_b} !== (act(p5) ? adr2(p5) : 12'h000))
        begin errors++; $display("FAIL scale_rgb k=%0d got=%h exp=%h", k, {b_b, g_b, r_b}, act(p5) ? adr2(p5) : 12'h000); end
    end
  endtask

  task automatic test_mid_reset;
    int p1, p5;
    repeat (20) @(negedge clk);
    checks++; if (hs_b !== hsa(pos_b(155))) begin errors++; $display("FAIL midrst_pre_hs got=%b exp=%b", hs_b, hsa(pos_b(155))); end
    rst_b = 1'b1;
    @(negedge clk);
    checks++; if (hs_b !== 1'b0 || vs_b !== 1'b0) begin errors++; $display("FAIL midrst_sync got=%b%b exp=00", hs_b, vs_b); end
    checks++; if (de_b !== 1'b0 || rd_b !== 1'b0) begin errors++; $display("FAIL midrst_de_rd got=%b%b exp=00", de_b, rd_b); end
    checks++; if (addr_b !== 12'd0) begin errors++; $display("FAIL midrst_addr got=%0d exp=0", addr_b); end
    checks++; if ({b_b, g_b, r_b} !== 12'h000) begin errors++; $display("FAIL midrst_rgb got=%h exp=000", {b_b, g_b, r_b}); end
    checks++; if (fs_b !== 1'b0) begin errors++; $display("FAIL midrst_fs got=%b exp=0", fs_b); end
    rst_b = 1'b0;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      p1 = pos_b(k - 1); p5 = pos_b(k - 5);
      checks++; if (fs_b !== (k == 0)) begin errors++; $display("FAIL restart_fs k=%0d got=%b exp=%b", k, fs_b, k == 0); end
      checks++; if (rd_b !== act(p1)) begin errors++; $display("FAIL restart_rd k=%0d got=%b exp=%b", k, rd_b, act(p1)); end
      if (act(p1)) begin
        checks++; if (addr_b !== adr2(p1)) begin errors++; $display("FAIL restart_addr k=%0d got=%0d exp=%0d", k, addr_b, adr2(p1)); end
      end
      checks++; if (de_b !== act(p5)) begin errors++; $display("FAIL restart_de k=%0d got=%b exp=%b", k, de_b, act(p5)); end
      checks++; if ({b_b, g_b, r_b} !== (act(p5) ? adr2(p5) : 12'h000))
        begin errors++; $display("FAIL restart_rgb k=%0d got=%h", k, {b_b, g_b, r_b}); end
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_sync_de;
    test_fetch_data;
    test_en_drop;
    test_scale_latency;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
